prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader: the writing end of the processor's instruction ROM interface.
- Receives a framed byte stream, assembles 16-bit instruction words, and writes them sequentially into program memory from address 0.
- Holds the processor in reset until a complete, checksum-verified image is loaded.
- Sits between the external byte source and the ROM write port; drives the processor's active-high rst input.

Parameters:
ROM_SIZE, 8, program memory address width; capacity 2^ROM_SIZE words

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
rx_valid  input  1  byte source has a byte on rx_data
rx_data  input  8  incoming byte
rx_ready  output  1  loader accepts byte; transfer occurs when rx_valid && rx_ready at a rising edge
prog_we  output  1  program memory write strobe, one-cycle pulse per word
prog_addr  output  ROM_SIZE  program memory write address
prog_data  output  16  program memory write data
cpu_rst  output  1  active-high reset to processor
done  output  1  image loaded and verified
err  output  1  frame error latched

Behaviour:
- Frame format, in order:
  - sync byte 0xA5
  - LEN_H, LEN_L: big-endian word count
  - LEN words, each high byte then low byte
  - CHK: XOR of every byte after sync, including both length bytes
- While rst=0, at the clock edge:
  - rx_ready=0, prog_we=0, prog_addr=0, prog_data=0, cpu_rst=1, done=0, err=0
  - state=IDLE, word counter=0, checksum accumulator=0
- rx_ready is a decode of state, forced to 0 while rst=0.
- States and transitions (all transitions on an accepted byte unless noted):
  - IDLE: rx_ready=1. 0xA5 goes to LEN_H and clears the accumulator; any other byte is discarded.
  - LEN_H: latch high length byte, XOR into accumulator, go to LEN_L.
  - LEN_L: latch low length byte, XOR into accumulator. LEN=0 or LEN>2^ROM_SIZE goes to ERR; otherwise go to DATA_H.
  - DATA_H: hold byte as high half, XOR into accumulator, go to DATA_L.
  - DATA_L: XOR into accumulator. On the next cycle: prog_we=1, prog_data={high,low}, prog_addr=word counter[ROM_SIZE-1:0]; counter then increments. If the incremented counter equals LEN, go to CHK; otherwise go to DATA_H.
  - CHK: byte equal to accumulator goes to DONE; mismatch goes to ERR.
  - DONE: rx_ready=0, done=1, cpu_rst=0. Terminal until rst.
  - ERR: err=1, cpu_rst=1, rx_ready=1. 0xA5 clears err, clears the accumulator and counter, and goes to LEN_H. Other bytes are discarded.
- Write latency: prog_we asserts exactly one cycle after the DATA_L byte is accepted.
  - prog_addr and prog_data hold their last values when prog_we=0.
  - At most one write per two accepted bytes, so back-to-back writes cannot occur.
- Word counter is ROM_SIZE+1 bits, so LEN=2^ROM_SIZE writes addresses 0..2^ROM_SIZE-1 with no wrap.
- No byte is lost or duplicated under arbitrary rx_valid gaps; state advances only on accepted bytes.
- Mid-frame rst: returns to the reset values above. Words already written are not undone; cpu_rst stays 1 until a later frame completes.
- On checksum mismatch, memory may hold a partial or bad image. It is never released to the processor.
- cpu_rst, done and err are registered, so there are no combinational paths from rx_* to them.

Test Plan:
- Nominal: bytes A5 00 02 12 34 AB CD 42 with rx_valid continuous -> writes (0,0x1234), (1,0xABCD), each prog_we a one-cycle pulse; done=1, cpu_rst=0 the cycle after CHK is accepted; rx_ready=0 afterwards.
- Sync hunt and backpressure: bytes 00 FF 5A, then the nominal frame with rx_valid low for 3 cycles between every byte -> garbage ignored, identical writes and final state to the nominal case.
- Bad checksum: nominal frame with CHK=0x43 -> both writes occur; err=1, done=0, cpu_rst=1. Then send the full nominal frame -> err clears on A5, ends with done=1.
- Length bounds (ROM_SIZE=8):
  - A5 01 01 -> err=1 after LEN_L, no prog_we.
  - A5 00 00 -> err=1, no writes.
  - A5 01 00, 256 words, correct CHK -> last write addr 0xFF; done=1.
- Reset mid-operation: drive rst=0 for one cycle after first word of nominal frame written -> all outputs at reset values (cpu_rst=1); nominal frame resent -> done=1, addresses restart at 0.
- Reset dominance: rst=0 with rx_valid=1, rx_data=0xA5 -> rx_ready=0, byte not consumed, state remains IDLE after release.

Source files
------------

// File: rtl/prog_loader.sv
// Boot-time program loader: parses an A5-framed byte stream into 16-bit words,
// writes them to program memory from address 0, and releases cpu_rst once the checksum matches.
module prog_loader #(
    parameter int ROM_SIZE = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rx_valid,
    input  logic [7:0]          rx_data,
    output logic                rx_ready,
    output logic                prog_we,
    output logic [ROM_SIZE-1:0] prog_addr,
    output logic [15:0]         prog_data,
    output logic                cpu_rst,
    output logic                done,
    output logic                err
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_H, S_LEN_L, S_DATA_H, S_DATA_L, S_CHK, S_DONE, S_ERR
    } state_e;

    localparam logic [7:0]  SYNC    = 8'hA5;
    localparam int unsigned MAX_LEN = 1 << ROM_SIZE;

    state_e                state_q, state_d;
    logic [7:0]            len_h_q, len_h_d;
    logic [ROM_SIZE:0]     len_q, len_d;
    logic [ROM_SIZE:0]     cnt_q, cnt_d;
    logic [7:0]            hi_q, hi_d;
    logic [7:0]            acc_q, acc_d;
    logic                  we_q, we_d;
    logic [ROM_SIZE-1:0]   addr_q, addr_d;
    logic [15:0]           data_q, data_d;
    logic                  cpu_rst_q, done_q, err_q;

    logic                  accept;
    logic [15:0]           len_full;
    logic [ROM_SIZE:0]     cnt_inc;

    assign rx_ready = rst && (state_q != S_DONE);
    assign accept   = rx_valid && rx_ready;
    assign len_full = {len_h_q, rx_data};
    assign cnt_inc  = cnt_q + 1'b1;

    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        len_h_d = len_h_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        acc_d   = acc_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        if (accept) begin
            unique case (state_q)
                S_IDLE, S_ERR: begin
                    if (rx_data == SYNC) begin
                        state_d = S_LEN_H;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                S_LEN_H: begin
                    len_h_d = rx_data;
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_LEN_L;
                end
                S_LEN_L: begin
                    acc_d = acc_q ^ rx_data;
                    if (len_full == '0 || {16'd0, len_full} > MAX_LEN) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = len_full[ROM_SIZE:0];
                        state_d = S_DATA_H;
                    end
                end
                S_DATA_H: begin
                    hi_d    = rx_data;
                    acc_d   = acc_q ^ rx_data;
                    state_d = S_DATA_L;
                end
                S_DATA_L: begin
                    // The write strobe is registered, so it lands one cycle after this byte.
                    acc_d   = acc_q ^ rx_data;
                    we_d    = 1'b1;
                    data_d  = {hi_q, rx_data};
                    addr_d  = cnt_q[ROM_SIZE-1:0];
                    cnt_d   = cnt_inc;
                    state_d = (cnt_inc == len_q) ? S_CHK : S_DATA_H;
                end
                S_CHK:   state_d = (rx_data == acc_q) ? S_DONE : S_ERR;
                default: state_d = state_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            len_h_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            acc_q     <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cpu_rst_q <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_h_q   <= len_h_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            acc_q     <= acc_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cpu_rst_q <= (state_d != S_DONE);
            done_q    <= (state_d == S_DONE);
            err_q     <= (state_d == S_ERR);
        end
    end

    assign prog_we   = we_q;
    assign prog_addr = addr_q;
    assign prog_data = data_q;
    assign cpu_rst   = cpu_rst_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: vector table, corner-case sequences,
// and randomized frames checked against a frame-level reference model.
module tb_prog_loader;

    localparam int ROM_SIZE = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                rx_valid;
    logic [7:0]          rx_data;
    logic                rx_ready;
    logic                prog_we;
    logic [ROM_SIZE-1:0] prog_addr;
    logic [15:0]         prog_data;
    logic                cpu_rst;
    logic                done;
    logic                err;

    prog_loader #(.ROM_SIZE(ROM_SIZE)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROM_SIZE-1:0] a;
        logic [15:0]         d;
    } wr_t;

    typedef struct {
        logic [0:15][7:0] b;
        int               n;
        int               gap;
        int               exp_nw;
        logic [15:0]      exp_d0;
        logic [15:0]      exp_dl;
        logic             exp_done;
        logic             exp_err;
    } vec_t;

    wr_t wq[$];
    logic we_prev = 1'b0;
    int   dbl = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    // Write monitor: records every strobe and flags back-to-back strobes.
    always @(negedge clk) begin
        if (prog_we) wq.push_back('{prog_addr, prog_data});
        if (prog_we && we_prev) dbl <= dbl + 1;
        we_prev <= prog_we;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int t = 0; t < 64 && !got; t++) begin
            @(negedge clk);
            got = rx_ready;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte 0x%0h not accepted within 64 cycles", b);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wq.delete();
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_nominal(input int gap);
        logic [0:7][7:0] nb;
        nb = 64'hA5000212_34ABCD42;
        for (int i = 0; i < 8; i++) send_byte(nb[i], gap);
    endtask

    task automatic check_status(input string tag, input logic exp_done, input logic exp_err);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!exp_done));
    endtask

    vec_t vecs[7];

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        // Reset state, including reset dominance over a valid sync byte.
        repeat (2) @(posedge clk);
        #1;
        check("rst_rx_ready", 32'(rx_ready), 32'd0);
        check("rst_prog_we", 32'(prog_we), 32'd0);
        check("rst_prog_addr", 32'(prog_addr), 32'd0);
        check("rst_prog_data", 32'(prog_data), 32'd0);
        check_status("rst", 1'b0, 1'b0);
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(negedge clk);
        check("rstdom_rx_ready", 32'(rx_ready), 32'd0);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rst      = 1'b1;
        wq.delete();
        #1;
        check("idle_rx_ready", 32'(rx_ready), 32'd1);
        begin
            logic [0:6][7:0] tail;
            tail = 56'h000212_34ABCD42;
            for (int i = 0; i < 7; i++) send_byte(tail[i], 0);
        end
        settle();
        check("rstdom_no_writes", 32'(wq.size()), 32'd0);
        check("rstdom_done", 32'(done), 32'd0);

        // Vector table.
        vecs[0] = '{{64'hA5000212_34ABCD42, 64'h0}, 8, 0, 2, 16'h1234, 16'hABCD, 1'b1, 1'b0};
        vecs[1] = '{{88'h00FF5AA5000212_34ABCD42, 40'h0}, 11, 3, 2, 16'h1234, 16'hABCD, 1'b1, 1'b0};
        vecs[2] = '{{64'hA5000212_34ABCD43, 64'h0}, 8, 0, 2, 16'h1234, 16'hABCD, 1'b0, 1'b1};
        vecs[3] = '{{24'hA50101, 104'h0}, 3, 0, 0, 16'h0, 16'h0, 1'b0, 1'b1};
        vecs[4] = '{{24'hA50000, 104'h0}, 3, 1, 0, 16'h0, 16'h0, 1'b0, 1'b1};
        vecs[5] = '{{48'hA50001_000706, 80'h0}, 6, 2, 1, 16'h0007, 16'h0007, 1'b1, 1'b0};
        vecs[6] = '{{88'hA50000_1122A50001BEEF50, 40'h0}, 11, 1, 1, 16'hBEEF, 16'hBEEF, 1'b1, 1'b0};
        for (int v = 0; v < 7; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            do_reset();
            for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i], vecs[v].gap);
            settle();
            check({tag, "_nwrites"}, 32'(wq.size()), 32'(vecs[v].exp_nw));
            if (vecs[v].exp_nw > 0 && wq.size() > 0) begin
                check({tag, "_d0"}, 32'(wq[0].d), 32'(vecs[v].exp_d0));
                check({tag, "_dlast"}, 32'(wq[$].d), 32'(vecs[v].exp_dl));
                for (int i = 0; i < wq.size(); i++)
                    check({tag, "_addr"}, 32'(wq[i].a), 32'(i));
            end
            check_status(tag, vecs[v].exp_done, vecs[v].exp_err);
            if (vecs[v].exp_done) check({tag, "_rx_ready_after"}, 32'(rx_ready), 32'd0);
        end

        // Write latency, pulse width, and hold of address/data.
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        check("lat_we_high", 32'(prog_we), 32'd1);
        check("lat_addr", 32'(prog_addr), 32'd0);
        check("lat_data", 32'(prog_data), 32'h1234);
        @(posedge clk);
        #1;
        check("lat_we_low", 32'(prog_we), 32'd0);
        check("lat_data_hold", 32'(prog_data), 32'h1234);
        send_byte(8'h27, 0);
        check_status("lat_chk", 1'b1, 1'b0);
        check("lat_rx_ready", 32'(rx_ready), 32'd0);

        // Bad checksum, then recovery with a full frame and no reset.
        do_reset();
        begin
            logic [0:7][7:0] bb;
            bb = 64'hA5000212_34ABCD43;
            for (int i = 0; i < 8; i++) send_byte(bb[i], 0);
        end
        settle();
        check_status("badchk", 1'b0, 1'b1);
        check("badchk_nwrites", 32'(wq.size()), 32'd2);
        send_byte(8'hA5, 0);
        check("recover_err_clear", 32'(err), 32'd0);
        begin
            logic [0:6][7:0] tail;
            tail = 56'h000212_34ABCD42;
            for (int i = 0; i < 7; i++) send_byte(tail[i], 0);
        end
        settle();
        check_status("recover", 1'b1, 1'b0);
        check("recover_nwrites", 32'(wq.size()), 32'd4);

        // Mid-frame reset after the first word lands.
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_rx_ready", 32'(rx_ready), 32'd0);
        check("midrst_prog_we", 32'(prog_we), 32'd0);
        check("midrst_prog_addr", 32'(prog_addr), 32'd0);
        check("midrst_prog_data", 32'(prog_data), 32'd0);
        check_status("midrst", 1'b0, 1'b0);
        rst = 1'b1;
        wq.delete();
        send_nominal(1);
        settle();
        check_status("midrst_resend", 1'b1, 1'b0);
        check("midrst_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            check("midrst_addr0", 32'(wq[0].a), 32'd0);
            check("midrst_data1", 32'(wq[1].d), 32'hABCD);
        end

        // Full-capacity image: 256 words, addresses 0..255.
        do_reset();
        begin
            logic [15:0] w[256];
            logic [7:0]  chk;
            int          bad;
            chk = 8'h01 ^ 8'h00;
            send_byte(8'hA5, 0);
            send_byte(8'h01, 0);
            send_byte(8'h00, 0);
            for (int i = 0; i < 256; i++) begin
                w[i] = 16'($urandom_range(0, 65535));
                chk  = chk ^ w[i][15:8] ^ w[i][7:0];
                send_byte(w[i][15:8], 0);
                send_byte(w[i][7:0], 0);
            end
            send_byte(chk, 0);
            settle();
            check("full_nwrites", 32'(wq.size()), 32'd256);
            if (wq.size() == 256) begin
                bad = 0;
                for (int i = 0; i < 256; i++)
                    if (wq[i].a !== 8'(i) || wq[i].d !== w[i]) bad++;
                check("full_contents_bad", 32'(bad), 32'd0);
                check("full_last_addr", 32'(wq[255].a), 32'hFF);
            end
            check_status("full", 1'b1, 1'b0);
        end

        // Randomized frames against the frame-level reference model.
        for (int it = 0; it < 40; it++) begin
            logic [15:0] exp_w[$];
            logic [7:0]  chk, g;
            int          len, ng, bad_chk, errs;
            do_reset();
            ng      = $urandom_range(0, 3);
            len     = $urandom_range(1, 6);
            bad_chk = ($urandom_range(0, 3) == 0) ? 1 : 0;
            for (int i = 0; i < ng; i++) begin
                g = 8'($urandom_range(0, 255));
                if (g == 8'hA5) g = 8'h00;
                send_byte(g, $urandom_range(0, 3));
            end
            send_byte(8'hA5, $urandom_range(0, 3));
            send_byte(8'h00, $urandom_range(0, 3));
            send_byte(8'(len), $urandom_range(0, 3));
            chk = 8'(len);
            for (int i = 0; i < len; i++) begin
                exp_w.push_back(16'($urandom_range(0, 65535)));
                chk = chk ^ exp_w[i][15:8] ^ exp_w[i][7:0];
                send_byte(exp_w[i][15:8], $urandom_range(0, 3));
                send_byte(exp_w[i][7:0], $urandom_range(0, 3));
            end
            if (bad_chk != 0) chk = chk ^ 8'($urandom_range(1, 255));
            send_byte(chk, $urandom_range(0, 3));
            settle();
            check("rand_nwrites", 32'(wq.size()), 32'(len));
            errs = 0;
            for (int i = 0; i < len && i < wq.size(); i++)
                if (wq[i].a !== 8'(i) || wq[i].d !== exp_w[i]) errs++;
            check("rand_contents_bad", 32'(errs), 32'd0);
            check_status("rand", bad_chk == 0, bad_chk != 0);
        end

        check("no_back_to_back_we", 32'(dbl), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
